// File: rtl/legv8_pkg.sv
// rtl/legv8_pkg.sv - shared LEGv8 opcodes, datapath select encodings and controller state
package legv8_pkg;

  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [10:0] OP_LSL  = 11'b11010011011;
  localparam logic [10:0] OP_LSR  = 11'b11010011010;
  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [7:0]  OP_CBZ_PFX = 8'b10110100;
  localparam logic [5:0]  OP_B_PFX   = 6'b000101;

  typedef enum logic [1:0] {
    EXT_D     = 2'd0,
    EXT_CB    = 2'd1,
    EXT_B     = 2'd2,
    EXT_SHAMT = 2'd3
  } ext_sel_t;

  typedef enum logic [3:0] {
    ALU_AND   = 4'b0000,
    ALU_ORR   = 4'b0001,
    ALU_ADD   = 4'b0010,
    ALU_SUB   = 4'b0110,
    ALU_PASSB = 4'b0111,
    ALU_LSL   = 4'b1000,
    ALU_LSR   = 4'b1001
  } alu_op_t;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    CL_RTYPE   = 3'd0,
    CL_LDUR    = 3'd1,
    CL_STUR    = 3'd2,
    CL_CBZ     = 3'd3,
    CL_B       = 3'd4,
    CL_ILLEGAL = 3'd5
  } iclass_t;

  typedef struct packed {
    iclass_t  cls;
    alu_op_t  alu_op;
    ext_sel_t ext_sel;
    logic     alu_src;
    logic     reg2loc;
    logic     illegal;
  } decode_t;

endpackage

// File: rtl/multicycle_control_if.sv
// rtl/multicycle_control_if.sv - controller-to-datapath/memory signal bundle
interface multicycle_control_if #(
  parameter int RETIRE_W = 32
);
  logic [10:0]         opcode;
  logic                zero;
  logic                mem_ready;
  logic                mem_req;
  logic                mem_we;
  logic                mem_sel;
  logic                ir_write;
  logic                pc_write;
  logic                pc_src;
  logic                reg2loc;
  logic                reg_write;
  logic                mem_to_reg;
  logic                alu_src;
  logic [3:0]          alu_op;
  logic [1:0]          ext_sel;
  logic                halted;
  logic [RETIRE_W-1:0] retired;

  modport master (
    input  opcode, zero, mem_ready,
    output mem_req, mem_we, mem_sel, ir_write, pc_write, pc_src, reg2loc,
           reg_write, mem_to_reg, alu_src, alu_op, ext_sel, halted, retired
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  mem_req, mem_we, mem_sel, ir_write, pc_write, pc_src, reg2loc,
           reg_write, mem_to_reg, alu_src, alu_op, ext_sel, halted, retired
  );
endinterface

// File: rtl/multicycle_control_opcode_decode.sv
// rtl/multicycle_control_opcode_decode.sv - combinational opcode classifier and select decode
module opcode_decode
  import legv8_pkg::*;
(
  input  logic [10:0] opcode,
  output decode_t     dec
);

  always_comb begin
    dec.cls     = CL_ILLEGAL;
    dec.alu_op  = ALU_PASSB;
    dec.ext_sel = EXT_D;
    dec.alu_src = 1'b0;
    dec.reg2loc = 1'b0;
    dec.illegal = 1'b1;
    // Branch prefixes carry immediate bits in the low opcode field, so they win over exact matches.
    if (opcode[10:5] == OP_B_PFX) begin
      dec.cls     = CL_B;
      dec.ext_sel = EXT_B;
      dec.illegal = 1'b0;
    end else if (opcode[10:3] == OP_CBZ_PFX) begin
      dec.cls     = CL_CBZ;
      dec.ext_sel = EXT_CB;
      dec.reg2loc = 1'b1;
      dec.illegal = 1'b0;
    end else begin
      case (opcode)
        OP_LDUR: begin
          dec.cls     = CL_LDUR;
          dec.alu_op  = ALU_ADD;
          dec.alu_src = 1'b1;
          dec.illegal = 1'b0;
        end
        OP_STUR: begin
          dec.cls     = CL_STUR;
          dec.alu_op  = ALU_ADD;
          dec.alu_src = 1'b1;
          dec.reg2loc = 1'b1;
          dec.illegal = 1'b0;
        end
        OP_LSL, OP_LSR: begin
          dec.cls     = CL_RTYPE;
          dec.alu_op  = (opcode == OP_LSL) ? ALU_LSL : ALU_LSR;
          dec.ext_sel = EXT_SHAMT;
          dec.alu_src = 1'b1;
          dec.illegal = 1'b0;
        end
        OP_ADD: begin
          dec.cls     = CL_RTYPE;
          dec.alu_op  = ALU_ADD;
          dec.illegal = 1'b0;
        end
        OP_SUB: begin
          dec.cls     = CL_RTYPE;
          dec.alu_op  = ALU_SUB;
          dec.illegal = 1'b0;
        end
        OP_AND: begin
          dec.cls     = CL_RTYPE;
          dec.alu_op  = ALU_AND;
          dec.illegal = 1'b0;
        end
        OP_ORR: begin
          dec.cls     = CL_RTYPE;
          dec.alu_op  = ALU_ORR;
          dec.illegal = 1'b0;
        end
        default: begin
          dec.cls     = CL_ILLEGAL;
          dec.illegal = 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multi-cycle LEGv8 control sequencer with shared memory port
module multicycle_control
  import legv8_pkg::*;
#(
  parameter int RETIRE_W = 32
) (
  input logic                  CLOCK,
  input logic                  RESET,
  multicycle_control_if.master bus
);

  state_t              state;
  state_t              state_nx;
  decode_t             dec;
  logic                retire;
  logic [RETIRE_W-1:0] retired_q;

  logic     mem_req, mem_we, mem_sel, ir_write, pc_write, pc_src;
  logic     reg2loc, reg_write, mem_to_reg, alu_src, halted;
  alu_op_t  alu_op;
  ext_sel_t ext_sel;

  opcode_decode u_decode (
    .opcode (bus.opcode),
    .dec    (dec)
  );

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state <= ST_FETCH;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_FETCH:  if (bus.mem_ready) state_nx = ST_DECODE;
      ST_DECODE: state_nx = dec.illegal ? ST_HALT : ST_EXEC;
      ST_EXEC: begin
        case (dec.cls)
          CL_RTYPE:         state_nx = ST_WB;
          CL_LDUR, CL_STUR: state_nx = ST_MEM;
          default:          state_nx = ST_FETCH;
        endcase
      end
      ST_MEM: begin
        if (bus.mem_ready) state_nx = (dec.cls == CL_STUR) ? ST_FETCH : ST_WB;
      end
      ST_WB:   state_nx = ST_FETCH;
      ST_HALT: state_nx = ST_HALT;
      default: state_nx = ST_FETCH;
    endcase
  end

  // Everything is gated by RESET so an aborted instruction can never leak a write or a retire.
  always_comb begin
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_sel    = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    reg2loc    = 1'b0;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    alu_src    = 1'b0;
    alu_op     = ALU_AND;
    ext_sel    = EXT_D;
    halted     = 1'b0;
    retire     = 1'b0;
    if (!RESET) begin
      if (state inside {ST_DECODE, ST_EXEC, ST_MEM, ST_WB}) begin
        alu_op  = dec.alu_op;
        ext_sel = dec.ext_sel;
        alu_src = dec.alu_src;
        reg2loc = dec.reg2loc;
      end
      case (state)
        ST_FETCH: begin
          mem_req  = 1'b1;
          ir_write = bus.mem_ready;
          pc_write = bus.mem_ready;
        end
        ST_EXEC: begin
          if (dec.cls == CL_B) begin
            pc_write = 1'b1;
            pc_src   = 1'b1;
            retire   = 1'b1;
          end else if (dec.cls == CL_CBZ) begin
            pc_write = bus.zero;
            pc_src   = 1'b1;
            retire   = 1'b1;
          end
        end
        ST_MEM: begin
          mem_req = 1'b1;
          mem_sel = 1'b1;
          mem_we  = (dec.cls == CL_STUR);
          retire  = (dec.cls == CL_STUR) && bus.mem_ready;
        end
        ST_WB: begin
          reg_write  = 1'b1;
          mem_to_reg = (dec.cls == CL_LDUR);
          retire     = 1'b1;
        end
        ST_HALT: halted = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      retired_q <= '0;
    end else if (retire) begin
      retired_q <= retired_q + RETIRE_W'(1);
    end
  end

  assign bus.mem_req    = mem_req;
  assign bus.mem_we     = mem_we;
  assign bus.mem_sel    = mem_sel;
  assign bus.ir_write   = ir_write;
  assign bus.pc_write   = pc_write;
  assign bus.pc_src     = pc_src;
  assign bus.reg2loc    = reg2loc;
  assign bus.reg_write  = reg_write;
  assign bus.mem_to_reg = mem_to_reg;
  assign bus.alu_src    = alu_src;
  assign bus.alu_op     = alu_op;
  assign bus.ext_sel    = ext_sel;
  assign bus.halted     = halted;
  assign bus.retired    = retired_q;

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - randomized self-checking bench for multicycle_control
module tb_multicycle_control;

  localparam logic [10:0] T_LDUR = 11'b11111000010;
  localparam logic [10:0] T_STUR = 11'b11111000000;
  localparam logic [10:0] T_LSL  = 11'b11010011011;
  localparam logic [10:0] T_LSR  = 11'b11010011010;
  localparam logic [10:0] T_ADD  = 11'b10001011000;
  localparam logic [10:0] T_SUB  = 11'b11001011000;
  localparam logic [10:0] T_AND  = 11'b10001010000;
  localparam logic [10:0] T_ORR  = 11'b10101010000;

  localparam int C_R = 0, C_SH = 1, C_LDUR = 2, C_STUR = 3, C_CBZ = 4, C_B = 5, C_ILL = 6;
  localparam int P_FETCH = 0, P_DECODE = 1, P_EXEC = 2, P_MEM = 3, P_WB = 4, P_HALT = 5;

  // Observation vector: {req, we, sel, ir_write, pc_write, pc_src, reg2loc, reg_write,
  //                      mem_to_reg, alu_src, alu_op[3:0], ext_sel[1:0], halted}
  localparam int B_REQ = 16, B_WE = 15, B_SEL = 14, B_IRW = 13, B_PCW = 12, B_PCS = 11;
  localparam int B_R2L = 10, B_RW = 9, B_M2R = 8, B_ASRC = 7, B_HALT = 0;
  localparam logic [16:0] M_ALU = 17'h00078;
  localparam logic [16:0] M_EXT = 17'h00006;
  localparam logic [16:0] M_STROBES = 17'h1B201;

  typedef struct {
    logic        rdy;
    logic [16:0] e;
    logic [16:0] m;
    int          ph;
  } cyc_t;

  logic CLOCK = 1'b0;
  logic RESET = 1'b1;
  always #5 CLOCK = ~CLOCK;

  multicycle_control_if #(.RETIRE_W(4)) bus ();
  multicycle_control #(.RETIRE_W(4)) dut (.CLOCK(CLOCK), .RESET(RESET), .bus(bus));

  wire [16:0] obs = {bus.mem_req, bus.mem_we, bus.mem_sel, bus.ir_write, bus.pc_write,
                     bus.pc_src, bus.reg2loc, bus.reg_write, bus.mem_to_reg, bus.alu_src,
                     bus.alu_op, bus.ext_sel, bus.halted};

  cyc_t        sched[$];
  logic [16:0] obs_q[$];
  int          vectors = 0;
  int          miscompares = 0;
  int          exp_ret = 0;

  function automatic string pname(input int p);
    case (p)
      P_FETCH:  return "FETCH";
      P_DECODE: return "DECODE";
      P_EXEC:   return "EXEC";
      P_MEM:    return "MEM";
      P_WB:     return "WB";
      default:  return "HALT";
    endcase
  endfunction

  function automatic int classify(input logic [10:0] op);
    if (op[10:5] == 6'b000101) return C_B;
    if (op[10:3] == 8'b10110100) return C_CBZ;
    if (op == T_LDUR) return C_LDUR;
    if (op == T_STUR) return C_STUR;
    if (op == T_LSL || op == T_LSR) return C_SH;
    if (op == T_ADD || op == T_SUB || op == T_AND || op == T_ORR) return C_R;
    return C_ILL;
  endfunction

  function automatic void push(input logic r, input logic [16:0] e, input logic [16:0] m, input int ph);
    cyc_t c;
    c.rdy = r;
    c.e   = e;
    c.m   = m;
    c.ph  = ph;
    sched.push_back(c);
  endfunction

  // Expected cycle-by-cycle behaviour of one instruction with fw fetch waits and mw data waits.
  function automatic void plan(input logic [10:0] op, input logic z, input int fw, input int mw,
                               input int halt_n);
    int          c = classify(op);
    logic [3:0]  aop = 4'b0111;
    logic [1:0]  ext = 2'd0;
    logic        asrc = 1'b0;
    logic [16:0] dmask, e, m;
    sched.delete();
    case (op)
      T_ADD, T_LDUR, T_STUR: aop = 4'b0010;
      T_SUB: aop = 4'b0110;
      T_AND: aop = 4'b0000;
      T_ORR: aop = 4'b0001;
      T_LSL: aop = 4'b1000;
      T_LSR: aop = 4'b1001;
      default: aop = 4'b0111;
    endcase
    dmask = M_ALU | M_EXT;
    case (c)
      C_R:    dmask = M_ALU;
      C_SH:   begin ext = 2'd3; asrc = 1'b1; end
      C_LDUR, C_STUR: begin ext = 2'd0; asrc = 1'b1; end
      C_CBZ:  ext = 2'd1;
      C_B:    begin ext = 2'd2; dmask = M_EXT; end
      default: dmask = '0;
    endcase
    for (int k = 0; k <= fw; k++) begin
      e = '0;
      e[B_REQ] = 1'b1;
      e[B_IRW] = (k == fw);
      e[B_PCW] = (k == fw);
      push(k == fw, e, M_STROBES | (17'd1 << B_SEL) | ((k == fw) ? (17'd1 << B_PCS) : 17'd0), P_FETCH);
    end
    e = '0;
    e[B_R2L] = (c == C_STUR || c == C_CBZ);
    e[6:3] = aop;
    e[2:1] = ext;
    push(logic'($urandom_range(0, 1)), e, M_STROBES | (17'd1 << B_R2L) | dmask, P_DECODE);
    if (c == C_ILL) begin
      for (int k = 0; k < halt_n; k++) begin
        e = '0;
        e[B_HALT] = 1'b1;
        push(logic'($urandom_range(0, 1)), e, 17'h1FFFF & ~(M_ALU | M_EXT), P_HALT);
      end
      return;
    end
    e = '0;
    e[6:3] = aop;
    e[2:1] = ext;
    e[B_ASRC] = asrc;
    m = M_STROBES | dmask | ((c != C_B) ? (17'd1 << B_ASRC) : 17'd0);
    if (c == C_B || (c == C_CBZ && z)) begin
      e[B_PCW] = 1'b1;
      e[B_PCS] = 1'b1;
      m |= (17'd1 << B_PCS);
    end
    push(logic'($urandom_range(0, 1)), e, m, P_EXEC);
    if (c == C_LDUR || c == C_STUR) begin
      for (int k = 0; k <= mw; k++) begin
        e = '0;
        e[6:3] = aop;
        e[2:1] = ext;
        e[B_REQ] = 1'b1;
        e[B_SEL] = 1'b1;
        e[B_WE]  = (c == C_STUR);
        push(k == mw, e, M_STROBES | (17'd1 << B_SEL) | dmask, P_MEM);
      end
    end
    if (c == C_R || c == C_SH || c == C_LDUR) begin
      e = '0;
      e[6:3] = aop;
      e[2:1] = ext;
      e[B_RW]  = 1'b1;
      e[B_M2R] = (c == C_LDUR);
      push(logic'($urandom_range(0, 1)), e, M_STROBES | (17'd1 << B_M2R) | dmask, P_WB);
    end
  endfunction

  function automatic logic [10:0] rand_legal();
    logic [10:0] op;
    case ($urandom_range(0, 9))
      0: op = T_ADD;
      1: op = T_SUB;
      2: op = T_AND;
      3: op = T_ORR;
      4: op = T_LSL;
      5: op = T_LSR;
      6: op = T_LDUR;
      7: op = T_STUR;
      8: op = {8'b10110100, 3'($urandom_range(0, 7))};
      default: op = {6'b000101, 5'($urandom_range(0, 31))};
    endcase
    return op;
  endfunction

  task automatic do_reset();
    @(negedge CLOCK);
    RESET = 1'b1;
    bus.mem_ready = 1'b0;
    @(posedge CLOCK);
    #1;
    RESET = 1'b0;
    exp_ret = 0;
  endtask

  task automatic play();
    obs_q.delete();
    foreach (sched[i]) begin
      @(negedge CLOCK);
      bus.mem_ready = sched[i].rdy;
      #1;
      obs_q.push_back(obs);
    end
    @(posedge CLOCK);
    #1;
  endtask

  task automatic test_reset();
    @(negedge CLOCK);
    RESET = 1'b1;
    bus.mem_ready = 1'b1;
    bus.opcode = T_ADD;
    bus.zero = 1'b0;
    #1;
    vectors++;
    if ((obs & (M_STROBES | (17'd1 << B_PCS) | (17'd1 << B_M2R))) !== 17'd0) begin
      miscompares++;
      $display("FAIL reset_strobes: got %05h want 00000 under mask", obs);
    end
    @(posedge CLOCK);
    #1;
    RESET = 1'b0;
    bus.mem_ready = 1'b0;
    exp_ret = 0;
    vectors++;
    if (bus.retired !== 4'd0) begin
      miscompares++;
      $display("FAIL reset_retired: got %0d want 0", bus.retired);
    end
  endtask

  task automatic test_instr(input string tag, input logic [10:0] op, input logic z,
                            input int fw, input int mw);
    bus.opcode = op;
    bus.zero = z;
    plan(op, z, fw, mw, 0);
    play();
    foreach (sched[i]) begin
      vectors++;
      if ((obs_q[i] & sched[i].m) !== (sched[i].e & sched[i].m)) begin
        miscompares++;
        $display("FAIL %s op=%b cyc%0d %s: got %05h want %05h mask %05h", tag, op, i,
                 pname(sched[i].ph), obs_q[i], sched[i].e, sched[i].m);
      end
    end
    exp_ret = (exp_ret + 1) % 16;
    vectors++;
    if (bus.retired !== 4'(exp_ret)) begin
      miscompares++;
      $display("FAIL %s_retired op=%b: got %0d want %0d", tag, op, bus.retired, exp_ret);
    end
  endtask

  task automatic test_halt();
    logic [10:0] op = 11'b11111111111;
    bus.opcode = op;
    bus.zero = 1'b0;
    plan(op, 1'b0, 1, 0, 20);
    play();
    foreach (sched[i]) begin
      vectors++;
      if ((obs_q[i] & sched[i].m) !== (sched[i].e & sched[i].m)) begin
        miscompares++;
        $display("FAIL halt cyc%0d %s: got %05h want %05h mask %05h", i, pname(sched[i].ph),
                 obs_q[i], sched[i].e, sched[i].m);
      end
    end
    vectors++;
    if (bus.retired !== 4'(exp_ret)) begin
      miscompares++;
      $display("FAIL halt_retired: got %0d want %0d", bus.retired, exp_ret);
    end
    @(negedge CLOCK);
    RESET = 1'b1;
    bus.mem_ready = 1'b0;
    bus.opcode = T_ADD;
    @(posedge CLOCK);
    #1;
    RESET = 1'b0;
    exp_ret = 0;
    @(negedge CLOCK);
    #1;
    vectors++;
    if (bus.halted !== 1'b0 || bus.mem_req !== 1'b1 || bus.mem_sel !== 1'b0) begin
      miscompares++;
      $display("FAIL halt_cleared: got halted=%b req=%b sel=%b want 0 1 0",
               bus.halted, bus.mem_req, bus.mem_sel);
    end
  endtask

  task automatic test_stur_reset();
    bus.opcode = T_STUR;
    bus.zero = 1'b0;
    plan(T_STUR, 1'b0, 0, 3, 0);
    while (sched.size() > 4) void'(sched.pop_back());
    play();
    foreach (sched[i]) begin
      vectors++;
      if ((obs_q[i] & sched[i].m) !== (sched[i].e & sched[i].m)) begin
        miscompares++;
        $display("FAIL stur_abort cyc%0d %s: got %05h want %05h mask %05h", i,
                 pname(sched[i].ph), obs_q[i], sched[i].e, sched[i].m);
      end
    end
    @(negedge CLOCK);
    RESET = 1'b1;
    bus.mem_ready = 1'b0;
    #1;
    vectors++;
    if (bus.mem_req !== 1'b0 || bus.mem_we !== 1'b0 || bus.reg_write !== 1'b0) begin
      miscompares++;
      $display("FAIL stur_abort_reset: got req=%b we=%b rw=%b want 0 0 0",
               bus.mem_req, bus.mem_we, bus.reg_write);
    end
    @(posedge CLOCK);
    #1;
    RESET = 1'b0;
    exp_ret = 0;
    vectors++;
    if (bus.retired !== 4'd0) begin
      miscompares++;
      $display("FAIL stur_abort_retired: got %0d want 0", bus.retired);
    end
    @(negedge CLOCK);
    #1;
    vectors++;
    if (bus.mem_req !== 1'b1 || bus.mem_sel !== 1'b0 || bus.mem_we !== 1'b0) begin
      miscompares++;
      $display("FAIL stur_abort_refetch: got req=%b sel=%b we=%b want 1 0 0",
               bus.mem_req, bus.mem_sel, bus.mem_we);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int n = 0; n < 16; n++) begin
      test_instr("wrap_b", {6'b000101, 5'($urandom_range(0, 31))}, logic'($urandom_range(0, 1)),
                 $urandom_range(0, 1), 0);
    end
    vectors++;
    if (bus.retired !== 4'd0) begin
      miscompares++;
      $display("FAIL wrap_final: got %0d want 0", bus.retired);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      test_instr("random", rand_legal(), logic'($urandom_range(0, 1)),
                 $urandom_range(0, 2), $urandom_range(0, 3));
    end
  endtask

  initial begin
    bus.mem_ready = 1'b0;
    bus.opcode = '0;
    bus.zero = 1'b0;
    test_reset();
    test_instr("add", T_ADD, 1'b0, 0, 0);
    test_instr("ldur_wait", T_LDUR, 1'b0, 0, 3);
    test_instr("cbz_taken", {8'b10110100, 3'b101}, 1'b1, 0, 0);
    test_instr("cbz_not_taken", {8'b10110100, 3'b010}, 1'b0, 0, 0);
    test_instr("stur", T_STUR, 1'b0, 2, 1);
    test_instr("lsl", T_LSL, 1'b0, 1, 0);
    test_halt();
    test_stur_reset();
    test_wrap();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
